// File: rtl/dsd_pkg.sv
// Shared definitions for the serial datapath cells: FSM state encoding and
// default operand width.
package dsd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first.
// Optional signed-overflow flag enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import dsd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             d_ser,
  output logic             d_ser_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             done
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] diff_r;
  logic             br_r;
  logic             bout_r;
  logic             d_s;
  logic             bo_s;
  logic             accept_s;
  logic             last_s;
  logic             run_s;

  full_subtractor u_cell (
    .a    (sa_r[0]),
    .b    (sb_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus accept / last-bit strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand shifters, borrow chain and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r   <= '0;
      sb_r   <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (accept_s) begin
      sa_r   <= a;
      sb_r   <= b;
      br_r   <= bin;
      cnt_r  <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (run_s) begin
      sa_r   <= {1'b0, sa_r[WIDTH-1:1]};
      sb_r   <= {1'b0, sb_r[WIDTH-1:1]};
      diff_r <= {d_s, diff_r[WIDTH-1:1]};
      br_r   <= bo_s;
      cnt_r  <= cnt_r + CNT_ONE;
      if (last_s) begin
        bout_r <= bo_s;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_r;

  // Signed overflow: borrow into the MSB differs from borrow out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (accept_s) begin
      ovf_r <= 1'b0;
    end else if (last_s) begin
      ovf_r <= br_r ^ bo_s;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign run_s       = (state_r == ST_RUN);
  assign busy        = (state_r != ST_IDLE);
  assign d_ser_valid = run_s;
  assign done        = (state_r == ST_DONE);
  assign d_ser       = run_s ? d_s : 1'b0;
  assign diff        = diff_r;
  assign bout        = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: arithmetic reference model,
// random and directed operations, reset-abort and back-to-back throughput.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         bin_i;
  logic         busy;
  logic         d_ser;
  logic         d_ser_valid;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         done;

  int n_cmp;
  int n_err;
  int cyc;
  int acc_cyc;
  int mon_k;
  res_t exp_q[$];
  int   acc_list[$];
  res_t held;
  res_t cur;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a_i),
    .b           (b_i),
    .bin         (bin_i),
    .busy        (busy),
    .d_ser       (d_ser),
    .d_ser_valid (d_ser_valid),
    .diff        (diff),
    .bout        (bout),
    .ovf         (ovf),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic
  function automatic res_t ref_sub(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    res_t r;
    int   ud;
    int   sd;
    int   sa;
    int   sb;
    ud     = int'(ta) - int'(tb) - int'(tbin);
    r.diff = ud[W-1:0];
    r.bout = (ud < 0);
    sa     = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb     = tb[W-1] ? int'(tb) - (1 << W) : int'(tb);
    sd     = sa - sb - int'(tbin);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    r.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
`else
    r.ovf  = (sd != sd);
`endif
    return r;
  endfunction

  // Timing model: an accept is possible W+2 edges after the previous one
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc = -1000;
      held    = '0;
      cur     = '0;
    end else begin
      cyc = cyc + 1;
      if (start && (cyc >= acc_cyc + W + 2)) begin
        acc_cyc = cyc;
        cur     = ref_sub(a_i, b_i, bin_i);
        exp_q.push_back(cur);
        acc_list.push_back(cyc);
      end
    end
  end

  // Monitor: control outputs every cycle, results popped on done
  always @(negedge clk) begin
    res_t got;
    mon_k = cyc - acc_cyc;
    check("busy", busy, (mon_k >= 0 && mon_k <= W));
    check("d_ser_valid", d_ser_valid, (mon_k >= 0 && mon_k < W));
    check("done", done, (mon_k == W));
    check("d_ser", d_ser, (mon_k >= 0 && mon_k < W) ? cur.diff[mon_k] : 1'b0);
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        got  = exp_q.pop_front();
        held = got;
      end
    end
    if (mon_k >= W) begin
      check("diff", diff, held.diff);
      check("bout", bout, held.bout);
      check("ovf", ovf, held.ovf);
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin, input bit wait_done);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    a_i = ta; b_i = tb; bin_i = tbin; start = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_cyc == cyc) got = 1'b1;
    end
    start = 1'b0;
    check("accept", got, 1'b1);
    if (wait_done) repeat (W + 2) @(posedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; acc_cyc = -1000;
    held = '0; cur = '0;
    start = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_d_ser", d_ser, 1'b0);
    check("rst_d_ser_valid", d_ser_valid, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_bout", bout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    run_op(8'h00, 8'h01, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 1'b1);
    run_op(8'h10, 8'h0F, 1'b1, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b1);

    // start pulsed mid-RUN must be ignored
    run_op(8'hC3, 8'h2D, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    a_i = 8'hFF; b_i = 8'h00; bin_i = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (W + 2) @(posedge clk);

    // reset in cycle 4 of RUN aborts the operation
    run_op(8'h33, 8'h11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_d_ser", d_ser, 1'b0);
    check("abort_d_ser_valid", d_ser_valid, 1'b0);
    check("abort_diff", diff, '0);
    check("abort_bout", bout, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h21, 8'h42, 1'b1, 1'b1);

    for (int n = 0; n < 25; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        repeat (3) @(posedge clk); #1;
        a_i = W'($urandom); b_i = W'($urandom); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      repeat ($urandom_range(W + 1, W + 4)) @(posedge clk);
    end
    repeat (W + 3) @(posedge clk);

    // start held high: accepts every W+2 edges
    acc_list.delete();
    @(posedge clk); #1 start = 1'b1;
    for (int n = 0; n < 25; n++) begin
      a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    check("held_accepts", acc_list.size(), 3);
    if (acc_list.size() == 3) begin
      check("held_gap1", acc_list[1] - acc_list[0], W + 2);
      check("held_gap2", acc_list[2] - acc_list[1], W + 2);
    end

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
